// File: rtl/mcpu_ram_arbiter_if.sv
// Bus bundle between the MCPU core, the MCPU GPU, the RAM array and the RAM arbiter.
// req/ack semantics: a requester raises req with stable address/data and holds it until
// the one-cycle ack pulse; on the edge ending the ack cycle it drops req or presents the
// next access, and a req still high in the following IDLE is a new access.
interface mcpu_ram_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_BITS  = 14
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_BITS-1:0]  cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cpu_ack;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  gpu_req;
   logic [ADDR_BITS-1:0]  gpu_addr;
   logic                  gpu_ack;
   logic [DATA_WIDTH-1:0] gpu_rdata;
   logic [ADDR_BITS-1:0]  mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, gpu_req, gpu_addr, mem_rdata,
      output cpu_ack, cpu_rdata, gpu_ack, gpu_rdata, mem_addr, mem_we, mem_wdata, busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, gpu_req, gpu_addr, mem_rdata,
      input  cpu_ack, cpu_rdata, gpu_ack, gpu_rdata, mem_addr, mem_we, mem_wdata, busy
   );
endinterface

// File: rtl/mcpu_ram_arbiter.sv
// Shares the single-port main RAM between MCPU core and GPU with GPU priority, fixed 4-cycle access.
// Optional CPU starvation guard enabled by defining MCPU_ARB_STARVE_GUARD_EN.
module mcpu_ram_arbiter #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_BITS    = 14,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   mcpu_ram_arbiter_if.slave   bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2,
      ST_ACK  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  owner_gpu_q;
   logic                  is_write_q;
   logic                  grant_cpu, grant_gpu;
   logic                  force_cpu;
   logic [ADDR_BITS-1:0]  mem_addr_q;
   logic                  mem_we_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic [DATA_WIDTH-1:0] gpu_rdata_q;

`ifdef MCPU_ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt_q;

   assign force_cpu = bus.cpu_req && (starve_cnt_q == 4'(STARVE_LIMIT));

   // Counts GPU grants the CPU has had to sit through; any CPU grant or idle CPU resets it.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q <= 4'd0;
      end else if (state_q == ST_IDLE) begin
         if (!bus.cpu_req || grant_cpu) begin
            starve_cnt_q <= 4'd0;
         end else if (grant_gpu) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
         end
      end
   end
`else
   assign force_cpu = 1'b0;
`endif

   a_starve_limit_range: assert property (@(posedge clk) disable iff (reset)
      (STARVE_LIMIT >= 1 && STARVE_LIMIT <= 15));

   always_comb begin
      state_d   = state_q;
      grant_cpu = 1'b0;
      grant_gpu = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.gpu_req && !force_cpu) begin
               grant_gpu = 1'b1;
               state_d   = ST_ADDR;
            end else if (bus.cpu_req) begin
               grant_cpu = 1'b1;
               state_d   = ST_ADDR;
            end
         end
         ST_ADDR: state_d = ST_WAIT;
         ST_WAIT: state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // mem_we defaults low every cycle so a CPU write strobes only during ADDR.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_gpu_q <= 1'b0;
         is_write_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         gpu_rdata_q <= '0;
      end else begin
         state_q  <= state_d;
         mem_we_q <= 1'b0;
         if (grant_gpu) begin
            mem_addr_q  <= bus.gpu_addr;
            owner_gpu_q <= 1'b1;
            is_write_q  <= 1'b0;
         end else if (grant_cpu) begin
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            mem_we_q    <= bus.cpu_we;
            owner_gpu_q <= 1'b0;
            is_write_q  <= bus.cpu_we;
         end
         if (state_q == ST_WAIT && !is_write_q) begin
            if (owner_gpu_q) begin
               gpu_rdata_q <= bus.mem_rdata;
            end else begin
               cpu_rdata_q <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.cpu_ack   = (state_q == ST_ACK) && !owner_gpu_q;
   assign bus.gpu_ack   = (state_q == ST_ACK) && owner_gpu_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.gpu_rdata = gpu_rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// Self-checking bench for mcpu_ram_arbiter: vector table of single accesses plus
// hand-written sequences for contention, starvation, reset and input-change cases.
module tb_mcpu_ram_arbiter;
   localparam int DW = 16;
   localparam int AW = 14;

   typedef struct {
      bit            gpu;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rd;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] dbg_state;

   mcpu_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) bus ();

   mcpu_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, two known words preloaded during reset.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (reset) begin
         ram[14'h0F7F] <= 16'hBEEF;
         ram[14'h0000] <= 16'h5A5A;
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   logic [DW-1:0] cpu_exp_q[$];
   logic [DW-1:0] gpu_exp_q[$];
   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int cpu_ack_cyc = 0, gpu_ack_cyc = 0;
   int cpu_acks = 0, gpu_acks = 0;
   int we_cnt = 0, we_cyc = 0, busy_cnt = 0;
   bit gpu_stream = 1'b0;
   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.mem_we === 1'b1) begin
         we_cnt++;
         we_cyc = cyc;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.cpu_ack === 1'b1) begin
         cpu_acks++;
         cpu_ack_cyc = cyc;
         if (cpu_exp_q.size() == 0) check("cpu_ack_unexpected", 32'(cpu_exp_q.size()), 1);
         else check("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_exp_q.pop_front()));
      end
      if (bus.gpu_ack === 1'b1) begin
         gpu_acks++;
         gpu_ack_cyc = cyc;
         if (gpu_exp_q.size() == 0) check("gpu_ack_unexpected", 32'(gpu_exp_q.size()), 1);
         else check("gpu_rdata", 32'(bus.gpu_rdata), 32'(gpu_exp_q.pop_front()));
         if (gpu_stream) gpu_exp_q.push_back(16'hBEEF);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},      32'(bus.busy),      0);
      check({tag, "_cpu_ack"},   32'(bus.cpu_ack),   0);
      check({tag, "_gpu_ack"},   32'(bus.gpu_ack),   0);
      check({tag, "_mem_we"},    32'(bus.mem_we),    0);
      check({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
      check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
      check({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 0);
      check({tag, "_gpu_rdata"}, 32'(bus.gpu_rdata), 0);
      check({tag, "_state"},     32'(dbg_state),     0);
   endtask

   task automatic run_access(input vec_t v);
      int  start, n0, lat;
      bit  done;
      we_cnt   = 0;
      busy_cnt = 0;
      done     = 1'b0;
      start    = cyc;
      if (v.gpu) begin
         bus.gpu_req  = 1'b1;
         bus.gpu_addr = v.addr;
         gpu_exp_q.push_back(v.exp_rd);
         n0 = gpu_acks;
      end else begin
         bus.cpu_req   = 1'b1;
         bus.cpu_we    = v.we;
         bus.cpu_addr  = v.addr;
         bus.cpu_wdata = v.wdata;
         cpu_exp_q.push_back(v.exp_rd);
         n0 = cpu_acks;
      end
      for (int i = 0; i < 10 && !done; i++) begin
         tick();
         if (i == 0) check("mem_addr_in_addr", 32'(bus.mem_addr), 32'(v.addr));
         if ((v.gpu ? gpu_acks : cpu_acks) != n0) done = 1'b1;
      end
      lat = (v.gpu ? gpu_ack_cyc : cpu_ack_cyc) - start;
      check("ack_latency", done ? 32'(lat) : 32'hFFFF_FFFF, 3);
      check("mem_we_cycles", 32'(we_cnt), (v.we && !v.gpu) ? 1 : 0);
      if (v.we && !v.gpu) check("mem_we_at_t1", 32'(we_cyc - start), 1);
      check("busy_cycles", 32'(busy_cnt), 3);
      bus.cpu_req = 1'b0;
      bus.gpu_req = 1'b0;
      tick();
   endtask

   initial begin
      int start, c0, g0;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic [DW-1:0] cpu_rd_model;

      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.gpu_req = 1'b0; bus.gpu_addr = '0;

      vecs[0] = '{gpu: 0, we: 1, addr: 14'h0800, wdata: 16'h1234, exp_rd: 16'h0000};
      vecs[1] = '{gpu: 0, we: 0, addr: 14'h0800, wdata: 16'h0000, exp_rd: 16'h1234};
      vecs[2] = '{gpu: 1, we: 0, addr: 14'h0F7F, wdata: 16'h0000, exp_rd: 16'hBEEF};
      vecs[3] = '{gpu: 0, we: 1, addr: 14'h3FFF, wdata: 16'hA5A5, exp_rd: 16'h1234};
      vecs[4] = '{gpu: 0, we: 0, addr: 14'h3FFF, wdata: 16'h0000, exp_rd: 16'hA5A5};
      vecs[5] = '{gpu: 1, we: 0, addr: 14'h0000, wdata: 16'h0000, exp_rd: 16'h5A5A};
      vecs[6] = '{gpu: 1, we: 0, addr: 14'h3FFF, wdata: 16'h0000, exp_rd: 16'hA5A5};
      vecs[7] = '{gpu: 0, we: 0, addr: 14'h0F7F, wdata: 16'h0000, exp_rd: 16'hBEEF};
      vecs[8] = '{gpu: 0, we: 1, addr: 14'h0001, wdata: 16'h00FF, exp_rd: 16'hBEEF};
      vecs[9] = '{gpu: 1, we: 0, addr: 14'h0001, wdata: 16'h0000, exp_rd: 16'h00FF};

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      foreach (vecs[i]) run_access(vecs[i]);
      cpu_rd_model = 16'hBEEF;

      // Random write / GPU readback / CPU readback triples
      for (int i = 0; i < 6; i++) begin
         ra = AW'($urandom_range(14'h1000, 14'h1FFF));
         rd = DW'($urandom_range(0, 16'hFFFF));
         run_access('{gpu: 0, we: 1, addr: ra, wdata: rd, exp_rd: cpu_rd_model});
         run_access('{gpu: 1, we: 0, addr: ra, wdata: 16'h0000, exp_rd: rd});
         run_access('{gpu: 0, we: 0, addr: ra, wdata: 16'h0000, exp_rd: rd});
         cpu_rd_model = rd;
      end

      // Simultaneous requests: GPU first, CPU sampled again at T+4
      start = cyc;
      c0 = cpu_acks;
      g0 = gpu_acks;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0800;
      bus.gpu_req = 1'b1; bus.gpu_addr = 14'h0F7F;
      cpu_exp_q.push_back(16'h1234);
      gpu_exp_q.push_back(16'hBEEF);
      for (int i = 0; i < 15 && cpu_acks == c0; i++) begin
         tick();
         if (gpu_acks != g0) bus.gpu_req = 1'b0;
      end
      check("both_gpu_ack_cycle", 32'(gpu_ack_cyc - start), 3);
      check("both_cpu_ack_cycle", 32'(cpu_ack_cyc - start), 7);
      check("both_gpu_ack_count", 32'(gpu_acks - g0), 1);
      bus.cpu_req = 1'b0;
      tick();

      // Continuous GPU traffic with the CPU waiting
      start = cyc;
      c0 = cpu_acks;
      g0 = gpu_acks;
      gpu_stream = 1'b1;
      cpu_exp_q.push_back(16'h1234);
      gpu_exp_q.push_back(16'hBEEF);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0800;
      bus.gpu_req = 1'b1; bus.gpu_addr = 14'h0F7F;
`ifdef MCPU_ARB_STARVE_GUARD_EN
      for (int i = 0; i < 40 && cpu_acks == c0; i++) tick();
      check("starve_cpu_ack_cycle", 32'(cpu_ack_cyc - start), 19);
      check("starve_gpu_acks", 32'(gpu_acks - g0), 4);
`else
      for (int i = 0; i < 100; i++) tick();
      check("starve_cpu_never_acked", 32'(cpu_acks - c0), 0);
      check("starve_gpu_acks", 32'(gpu_acks - g0), 25);
`endif
      bus.cpu_req = 1'b0;
      bus.gpu_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      gpu_stream = 1'b0;
      cpu_exp_q.delete();
      gpu_exp_q.delete();
      check("starve_drained_idle", 32'(bus.busy), 0);

      // Reset during WAIT of a CPU read
      c0 = cpu_acks;
      cpu_exp_q.push_back(16'hA5A5);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h3FFF;
      tick();
      tick();
      check("pre_reset_in_wait", 32'(dbg_state), 2);
      reset = 1'b1;
      tick();
      check_all_zero("midreset");
      check("midreset_no_ack", 32'(cpu_acks - c0), 0);
      cpu_exp_q.delete();
      cpu_exp_q.push_back(16'hA5A5);
      reset = 1'b0;
      start = cyc;
      for (int i = 0; i < 10 && cpu_acks == c0; i++) tick();
      check("post_reset_ack_cycle", 32'(cpu_ack_cyc - start), 3);
      check("post_reset_ack_count", 32'(cpu_acks - c0), 1);
      bus.cpu_req = 1'b0;
      tick();

      // Address/we change during WAIT is ignored
      c0 = cpu_acks;
      we_cnt = 0;
      cpu_exp_q.push_back(16'hBEEF);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0F7F;
      tick();
      tick();
      bus.cpu_addr = 14'h0800;
      bus.cpu_we   = 1'b1;
      check("chg_mem_addr_wait", 32'(bus.mem_addr), 32'h0F7F);
      for (int i = 0; i < 6 && cpu_acks == c0; i++) tick();
      check("chg_mem_addr_ack", 32'(bus.mem_addr), 32'h0F7F);
      check("chg_ack_count", 32'(cpu_acks - c0), 1);
      check("chg_no_write", 32'(we_cnt), 0);
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      tick();
      tick();
      check("final_cpu_q_empty", 32'(cpu_exp_q.size()), 0);
      check("final_gpu_q_empty", 32'(gpu_exp_q.size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/mcpu_ram_arbiter.md
# mcpu_ram_arbiter

Two-port arbiter that shares the single-port main RAM between the MCPU core and the MCPU GPU. Sits in `top` between the core's RAM port, the GPU's memory port and the RAM array. It sequences every access through a fixed four-state FSM and gives the GPU priority, because scanout is latency-critical. An optional starvation guard bounds CPU wait time.

## Interface
Parameters:
- `DATA_WIDTH`, 16, RAM word width.
- `ADDR_BITS`, 14, RAM address width (word addressed).
- `STARVE_LIMIT`, 4, consecutive GPU grants allowed while CPU waits. Used only with the guard enabled; legal range 1..15.

Ports:
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request; held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr` in ADDR_BITS: CPU address; stable while `cpu_req`.
- `cpu_wdata` in DATA_WIDTH: CPU write data; stable while `cpu_req`.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out DATA_WIDTH: read data; valid in the `cpu_ack` cycle and held until the next CPU read completes.
- `gpu_req` in 1: GPU read request; held until `gpu_ack`.
- `gpu_addr` in ADDR_BITS: GPU address; stable while `gpu_req`.
- `gpu_ack` out 1: one-cycle completion pulse.
- `gpu_rdata` out DATA_WIDTH: read data; valid in the `gpu_ack` cycle and held until the next GPU read.
- `mem_addr` out ADDR_BITS: registered RAM address.
- `mem_we` out 1: registered RAM write enable.
- `mem_wdata` out DATA_WIDTH: registered RAM write data.
- `mem_rdata` in DATA_WIDTH: RAM read data, synchronous, one cycle after `mem_addr`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE -> ADDR -> WAIT -> ACK -> IDLE. Every transition is unconditional except leaving IDLE.
- IDLE: sample the requests.
  - No request: stay in IDLE.
  - Otherwise pick a winner, register its address (and write data/we for CPU) into `mem_*`, latch `owner`, go to ADDR.
- Priority: GPU wins when both request. CPU wins only when `gpu_req`=0, or when the starvation guard forces it.
- ADDR: RAM samples `mem_addr`.
  - `mem_we`=1 here only for a CPU write, for exactly this one cycle.
  - GPU accesses are never writes.
- WAIT: `mem_we`=0; `mem_addr` held; `mem_rdata` is valid.
  - On a read, latch it into the owner's rdata register at the end of WAIT.
- ACK: pulse the owner's ack for one cycle, then return to IDLE.
- CPU write: `cpu_rdata` is not updated.
- Requesters drop `req`, or present a new transaction, on the clock edge ending their ack cycle. `req` still high in the following IDLE is a new access.
- Inputs are sampled only in IDLE. Changes during ADDR/WAIT/ACK are ignored.
- Addresses pass through unmodified. There is no decoding or wrap logic; ROM-mapped reads above RAM stay in `top`.

## Timing
- Request sampled in IDLE at cycle T: `mem_addr`/`mem_we` valid in T+1, rdata latched end of T+2, ack high in T+3.
- Latency: 3 cycles from request sample to ack; one access per 4 cycles.
- The earliest next sample is T+4.
- Worst-case GPU wait with the CPU mid-access: 3 extra cycles.
- Reset values: state IDLE, and every output is 0. This covers `mem_*`, `cpu_ack`, `gpu_ack`, `busy`, `cpu_rdata`, `gpu_rdata`. The starvation counter is 0.
- Reset mid-operation: the access is abandoned and no ack is issued.
  - `mem_we` is 0 from the cycle after reset is sampled.
  - A write whose ADDR cycle already completed is not undone.
- Both requests in the same IDLE: one grant only. The loser keeps `req` high and is sampled again at T+4.

## Configuration
- `MCPU_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each GPU grant made while `cpu_req`=1.
  - It clears on any CPU grant and whenever IDLE sees `cpu_req`=0.
  - When the counter equals `STARVE_LIMIT` and `cpu_req`=1, the CPU wins regardless of `gpu_req`.
- Undefined: strict GPU priority, no counter logic. The `STARVE_LIMIT` parameter remains but is unused.

## Test plan
- CPU write: `cpu_addr`=0x0800, wdata=0x1234 with `gpu_req`=0 -> `mem_we`=1 for one cycle at T+1, `cpu_ack` at T+3. A following read of 0x0800 returns `cpu_rdata`=0x1234 at its ack.
- GPU read: `gpu_addr`=0x0F7F with RAM preloaded to 0xBEEF -> `gpu_ack` at T+3 with `gpu_rdata`=0xBEEF, `mem_we` never 1, `busy` high T+1..T+3.
- Simultaneous requests: `cpu_req` and `gpu_req` both high in the same IDLE -> GPU acked at T+3, CPU granted at T+4 and acked at T+7.
- Continuous `gpu_req` with `cpu_req` held and `STARVE_LIMIT`=4:
  - Guard enabled: the CPU is granted after the 4th GPU ack, i.e. its ack lands at cycle 19.
  - Guard disabled: `cpu_ack` never asserts over 100 cycles.
- Reset asserted during WAIT of a CPU read -> no `cpu_ack`, and all outputs are 0 the next cycle. After release, a held `cpu_req` completes normally 3 cycles after the first IDLE.
- Requester changes `cpu_addr` during WAIT -> `mem_addr` unchanged, and data comes from the originally sampled address.
